// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI SCLK burst generator.
package spi_pkg;

  localparam int unsigned DIV_W_DEF = 16;
  localparam int unsigned BIT_W_DEF = 6;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    GUARD = 2'd2
  } state_e;

  // SPI modes encoded as {cpol, cpha}.
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  // Strobe pair produced for one SCLK edge.
  typedef struct packed {
    logic sample;
    logic shift;
  } strobe_t;

  // Maps an SCLK edge to its sample/shift strobe for the given clock phase.
  // With cpha=0 the final trailing edge drives no new bit: the word is complete.
  function automatic strobe_t edge_strobes(input logic cpha,
                                           input logic leading,
                                           input logic last);
    strobe_t s;
    s.sample = cpha ? ~leading : leading;
    s.shift  = cpha ? leading  : (~leading & ~last);
    return s;
  endfunction

endpackage

// File: rtl/spi_hp_counter.sv
// Half-period down-counter: loadable, reloads at zero and flags that cycle.
// The tick is combinational so the cycle that loads the counter already
// counts as the first cycle of the half-period.
module spi_hp_counter
  import spi_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] load_val_i,
  input  logic [DIV_W-1:0] reload_val_i,
  output logic             tick_c_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic [DIV_W-1:0] cur_c;
  logic [DIV_W-1:0] reload_c;
  logic             active_c;
  logic             tick_c;

  // Effective count this cycle, zero detect and next count.
  always_comb begin
    active_c = en_i | load_i;
    cur_c    = load_i ? load_val_i : cnt_q;
    reload_c = load_i ? load_val_i : reload_val_i;
    tick_c   = active_c && (cur_c == '0);
    cnt_d    = cnt_q;
    if (active_c) begin
      cnt_d = tick_c ? reload_c : (cur_c - DIV_W'(1));
    end
  end

  assign tick_c_o = tick_c;

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_sclk_gen.sv
// Bursted SPI SCLK generator with run-time half-period, mode and bit count,
// plus registered sample/shift strobes aligned to the SCLK edges.
// Optional macro SPI_SCLK_BITIDX_EN adds the bit_idx output.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF,
  parameter int unsigned BIT_W = BIT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIV_W-1:0] div,
  input  logic             cpol,
  input  logic             cpha,
  input  logic [BIT_W-1:0] nbits,
  input  logic             abort,
  output logic             busy,
  output logic             sclk,
  output logic             sample,
  output logic             shift,
`ifdef SPI_SCLK_BITIDX_EN
  output logic [BIT_W-1:0] bit_idx,
`endif
  output logic             done
);

  localparam int unsigned EDGE_W = BIT_W + 1;

  state_e              state_q, state_d;
  logic                busy_q, busy_d;
  logic                sclk_q, sclk_d;
  logic                sample_q, sample_d;
  logic                shift_q, shift_d;
  logic                done_q, done_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                cpol_q, cpol_d;
  logic                cpha_q, cpha_d;
  logic [EDGE_W-1:0]   edges_q, edges_d;
`ifdef SPI_SCLK_BITIDX_EN
  logic [BIT_W-1:0]    nbits_q, nbits_d;
  logic [BIT_W-1:0]    bit_idx_q, bit_idx_d;
`endif

  logic                accept_c;
  logic                cnt_en_c;
  logic                tick_c;
  logic                edge_c;
  logic                guard_tick_c;
  logic [EDGE_W-1:0]   edges_cur_c;
  logic                cpha_cur_c;
  logic                lead_c;
  logic                last_c;
  strobe_t             stb_c;

  // A start is taken only in IDLE, not in the done cycle, not with abort,
  // and only for a non-empty burst.
  assign accept_c = (state_q == IDLE) && start && !abort && !done_q && (nbits != '0);

  // The counter runs from the accept cycle until GUARD expires or abort.
  assign cnt_en_c = accept_c || (((state_q == RUN) || (state_q == GUARD)) && !abort);

  // In the accept cycle the config is not yet latched, so use the live inputs.
  assign edges_cur_c = accept_c ? {nbits, 1'b0} : edges_q;
  assign cpha_cur_c  = accept_c ? cpha : cpha_q;

  assign edge_c       = tick_c && (accept_c || ((state_q == RUN) && !abort));
  assign guard_tick_c = tick_c && (state_q == GUARD) && !abort;

  spi_hp_counter #(
    .DIV_W (DIV_W)
  ) u_hp_counter (
    .clk          (clk),
    .rst          (rst),
    .en_i         (cnt_en_c),
    .load_i       (accept_c),
    .load_val_i   (div),
    .reload_val_i (div_q),
    .tick_c_o     (tick_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    sclk_d   = sclk_q;
    sample_d = 1'b0;
    shift_d  = 1'b0;
    done_d   = 1'b0;
    div_d    = div_q;
    cpol_d   = cpol_q;
    cpha_d   = cpha_q;
    edges_d  = edges_q;
    lead_c   = 1'b0;
    last_c   = 1'b0;
    stb_c    = '0;
`ifdef SPI_SCLK_BITIDX_EN
    nbits_d   = nbits_q;
    bit_idx_d = bit_idx_q;
`endif

    unique case (state_q)
      IDLE: begin
        sclk_d = cpol;
        if (accept_c) begin
          state_d = RUN;
          busy_d  = 1'b1;
          div_d   = div;
          cpol_d  = cpol;
          cpha_d  = cpha;
          edges_d = edges_cur_c;
`ifdef SPI_SCLK_BITIDX_EN
          nbits_d   = nbits;
          bit_idx_d = '0;
`endif
        end else if (start && !abort && !done_q) begin
          // Empty burst: completes immediately without touching SCLK.
          done_d = 1'b1;
        end
      end
      RUN, GUARD: begin
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          sclk_d  = cpol_q;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // SCLK edge: toggle, emit strobe, count down remaining edges.
    if (edge_c) begin
      lead_c   = ~edges_cur_c[0];
      last_c   = (edges_cur_c == EDGE_W'(1));
      stb_c    = edge_strobes(cpha_cur_c, lead_c, last_c);
      sample_d = stb_c.sample;
      shift_d  = stb_c.shift;
      sclk_d   = ~sclk_d;
      edges_d  = edges_cur_c - EDGE_W'(1);
      if (last_c) begin
        state_d = GUARD;
      end
`ifdef SPI_SCLK_BITIDX_EN
      if (!lead_c && (bit_idx_q != (nbits_q - BIT_W'(1)))) begin
        bit_idx_d = bit_idx_q + BIT_W'(1);
      end
`endif
    end

    // Trailing guard half-period over: report completion.
    if (guard_tick_c) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      sclk_q    <= 1'b0;
      sample_q  <= 1'b0;
      shift_q   <= 1'b0;
      done_q    <= 1'b0;
      div_q     <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      edges_q   <= '0;
`ifdef SPI_SCLK_BITIDX_EN
      nbits_q   <= '0;
      bit_idx_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      sclk_q    <= sclk_d;
      sample_q  <= sample_d;
      shift_q   <= shift_d;
      done_q    <= done_d;
      div_q     <= div_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      edges_q   <= edges_d;
`ifdef SPI_SCLK_BITIDX_EN
      nbits_q   <= nbits_d;
      bit_idx_q <= bit_idx_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign sclk   = sclk_q;
  assign sample = sample_q;
  assign shift  = shift_q;
  assign done   = done_q;
`ifdef SPI_SCLK_BITIDX_EN
  assign bit_idx = bit_idx_q;
`endif

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Bench for spi_sclk_gen: closed-form timing model checked every cycle,
// directed bursts with literal expectations, then randomized traffic.
module tb_spi_sclk_gen;
  import spi_pkg::*;

  localparam int unsigned DIV_W = 16;
  localparam int unsigned BIT_W = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [DIV_W-1:0] div = '0;
  logic             cpol = 1'b0;
  logic             cpha = 1'b0;
  logic [BIT_W-1:0] nbits = '0;
  logic             abort = 1'b0;
  logic             busy, sclk, sample, shift, done;
`ifdef SPI_SCLK_BITIDX_EN
  logic [BIT_W-1:0] bit_idx;
`endif

  spi_sclk_gen #(.DIV_W(DIV_W), .BIT_W(BIT_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .div    (div),
    .cpol   (cpol),
    .cpha   (cpha),
    .nbits  (nbits),
    .abort  (abort),
    .busy   (busy),
    .sclk   (sclk),
    .sample (sample),
    .shift  (shift),
`ifdef SPI_SCLK_BITIDX_EN
    .bit_idx(bit_idx),
`endif
    .done   (done)
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  logic chk_on = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A burst accepted in cycle T0 is fully described by arithmetic on (u - T0).
  bit   m_act = 1'b0;
  int   m_t0 = 0, m_tend = 0, m_d = 0, m_n = 0;
  logic m_cpol = 1'b0, m_cpha = 1'b0;
  logic e_busy = 1'b0, e_sclk = 1'b0, e_sample = 1'b0, e_shift = 1'b0, e_done = 1'b0;
  int   e_bitidx = 0;

  task automatic eval_at(input int u);
    int rel, h, ph, e;
    rel = u - m_t0;
    h   = rel / (m_d + 1);
    ph  = rel % (m_d + 1);
    e   = (h > 2 * m_n) ? 2 * m_n : h;
    e_sclk   = m_cpol ^ e[0];
    e_busy   = (u < m_tend);
    e_done   = (u == m_tend);
    e_sample = 1'b0;
    e_shift  = 1'b0;
    if (ph == 0 && h >= 1 && h <= 2 * m_n) begin
      if (h % 2 == 1) begin
        if (m_cpha) e_shift = 1'b1; else e_sample = 1'b1;
      end else begin
        if (m_cpha) e_sample = 1'b1; else if (h != 2 * m_n) e_shift = 1'b1;
      end
    end
    e_bitidx = (e / 2 > m_n - 1) ? m_n - 1 : e / 2;
  endtask

  // Compute expected outputs for the next cycle from this cycle's inputs.
  always @(posedge clk) begin
    int   t;
    logic go, inb;
    t = cyc;
    if (!rst) begin
      m_act = 1'b0;
      e_busy = 1'b0; e_sclk = 1'b0; e_sample = 1'b0; e_shift = 1'b0; e_done = 1'b0;
      e_bitidx = 0;
    end else begin
      inb = m_act && (t > m_t0) && (t < m_tend);
      go  = start && !abort && !e_done;
      if (inb && abort) begin
        m_act = 1'b0;
        e_busy = 1'b0; e_sclk = m_cpol; e_sample = 1'b0; e_shift = 1'b0; e_done = 1'b0;
      end else if (inb) begin
        eval_at(t + 1);
      end else if (go && nbits != '0) begin
        m_act = 1'b1; m_t0 = t;
        m_d = int'(div); m_n = int'(nbits); m_cpol = cpol; m_cpha = cpha;
        m_tend = t + (2 * m_n + 1) * (m_d + 1);
        eval_at(t + 1);
      end else begin
        e_busy = 1'b0; e_sclk = cpol; e_sample = 1'b0; e_shift = 1'b0; e_done = go;
      end
    end
    cyc = cyc + 1;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst && chk_on) begin
      chk("outputs{busy,sclk,sample,shift,done}", {busy, sclk, sample, shift, done},
          {e_busy, e_sclk, e_sample, e_shift, e_done});
      chk("sample_shift_exclusive", sample & shift, 0);
`ifdef SPI_SCLK_BITIDX_EN
      chk("bit_idx", bit_idx, e_bitidx);
`endif
    end
  end

  // ---------------- directed helpers ----------------
  int   w_s, w_sh, w_sh_lo, w_tog, w_first, w_done, w_bimax, w_bidone, w_bifirst;
  logic w_busy, w_last;

  task automatic launch(input int d, input logic [1:0] mode, input int n, output int t0);
    div = DIV_W'(d); {cpol, cpha} = mode; nbits = BIT_W'(n); start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic watch(input int budget, input logic idle_lvl);
    logic prev;
    prev = idle_lvl;
    w_s = 0; w_sh = 0; w_sh_lo = 0; w_tog = 0; w_first = -1; w_done = -1;
    w_bimax = 0; w_bidone = -1; w_bifirst = -1; w_busy = 1'b0; w_last = idle_lvl;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sample) w_s++;
      if (shift) begin w_sh++; if (!sclk) w_sh_lo++; end
      if (sclk != prev) begin w_tog++; if (w_first < 0) w_first = cyc; end
      prev = sclk;
      w_busy = w_busy | busy;
      w_last = sclk;
`ifdef SPI_SCLK_BITIDX_EN
      if (i == 0) w_bifirst = int'(bit_idx);
      if (int'(bit_idx) > w_bimax) w_bimax = int'(bit_idx);
      if (done && w_done < 0) w_bidone = int'(bit_idx);
`endif
      if (done && w_done < 0) w_done = cyc;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int t0, t1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_sclk", sclk, 0);
    chk("reset_sample", sample, 0);
    chk("reset_shift", shift, 0);
    chk("reset_done", done, 0);
    #2 rst = 1'b1;
    chk_on = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Mode 0, div=1, 8 bits.
    launch(1, MODE0, 8, t0);
    watch(40, 1'b0);
    chk("m0_first_rise", w_first, t0 + 2);
    chk("m0_samples", w_s, 8);
    chk("m0_shifts", w_sh, 7);
    chk("m0_toggles", w_tog, 16);
    chk("m0_done_cycle", w_done, t0 + 34);

    // Mode 3, div=0, 4 bits.
    launch(0, MODE3, 4, t0);
    watch(15, 1'b1);
    chk("m3_first_edge", w_first, t0 + 1);
    chk("m3_toggles", w_tog, 8);
    chk("m3_samples", w_s, 4);
    chk("m3_shift_on_fall", w_sh_lo, 4);
    chk("m3_done_cycle", w_done, t0 + 9);
    chk("m3_end_level", w_last, 1);

    // Empty burst.
    launch(5, MODE0, 0, t0);
    watch(6, 1'b0);
    chk("n0_busy_seen", w_busy, 0);
    chk("n0_done_cycle", w_done, t0 + 1);
    chk("n0_toggles", w_tog, 0);

    // Abort in the middle of a mode-1 burst, then restart.
    launch(3, MODE1, 8, t0);
    repeat (4) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_sclk", sclk, 0);
    chk("abort_done", done, 0);
    @(posedge clk); #1;
    launch(3, MODE1, 8, t1);
    chk("restart_cycle", t1, t0 + 7);
    watch(75, 1'b0);
    chk("restart_busy_seen", w_busy, 1);
    chk("restart_samples", w_s, 8);
    chk("restart_shifts", w_sh, 8);
    chk("restart_done_cycle", w_done, t1 + 68);

    // Start pulse with new config while busy must not disturb the burst.
    launch(2, MODE0, 3, t0);
    @(posedge clk); #1;
    div = DIV_W'(0); cpol = 1'b1; cpha = 1'b1; nbits = BIT_W'(7); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cpol = 1'b0;
    watch(25, 1'b0);
    chk("busy_start_toggles", w_tog, 6);
    chk("busy_start_samples", w_s, 3);
    chk("busy_start_shifts", w_sh, 2);
    chk("busy_start_done_cycle", w_done, t0 + 21);

    // Largest bit count at full speed.
    launch(0, MODE0, 63, t0);
    watch(130, 1'b0);
    chk("n63_toggles", w_tog, 126);
    chk("n63_samples", w_s, 63);
    chk("n63_shifts", w_sh, 62);
    chk("n63_done_cycle", w_done, t0 + 127);

`ifdef SPI_SCLK_BITIDX_EN
    launch(1, MODE0, 5, t0);
    watch(25, 1'b0);
    chk("bitidx_first", w_bifirst, 0);
    chk("bitidx_max", w_bimax, 4);
    chk("bitidx_at_done", w_bidone, 4);
    chk("bitidx_done_cycle", w_done, t0 + 22);
`endif

    // Asynchronous reset mid-burst while sclk is high with cpol=1.
    launch(3, MODE2, 8, t0);
    repeat (8) begin @(posedge clk); #1; end
    chk("pre_rst_sclk", sclk, 1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_sclk", sclk, 0);
    chk("midrst_sample", sample, 0);
    chk("midrst_shift", shift, 0);
    chk("midrst_done", done, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_sclk", sclk, 1);
    chk("post_rst_busy", busy, 0);

    // Randomized traffic.
    for (int i = 0; i < 2500; i++) begin
      start = ($urandom_range(0, 5) == 0);
      abort = ($urandom_range(0, 79) == 0);
      div   = DIV_W'($urandom_range(0, 4));
      nbits = ($urandom_range(0, 9) == 0) ? BIT_W'(0) : BIT_W'($urandom_range(1, 9));
      cpol  = 1'($urandom_range(0, 1));
      cpha  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    start = 1'b0;
    abort = 1'b0;
    repeat (80) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
